// File: rtl/motor_pkg.sv
// motor_pkg: default constants and helpers shared by the motor input conditioner.
// Rev 1.0
`default_nettype none

package motor_pkg;

  localparam int MOTOR_DEBOUNCE_CYCLES = 1000;
  localparam int MOTOR_SYNC_STAGES     = 2;

  // Channel slots within the packed raw/stable vectors of motor_inputs.
  typedef enum logic [1:0] {
    CH_BTN = 2'd0,
    CH_UP  = 2'd1,
    CH_DN  = 2'd2
  } motor_ch_e;

  localparam int MOTOR_NUM_CH = 3;

  function automatic int motor_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/motor_inputs_debounce.sv
// debounce: synchroniser, hold counter and stable-state register for one bouncy input.
// Rev 1.0
`default_nettype none

module debounce
  import motor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = MOTOR_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = MOTOR_SYNC_STAGES,
  parameter int CNT_W           = motor_cnt_w(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;

  logic w_sync;
  logic w_differ;
  logic w_done;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_differ = w_sync ^ r_stable;
  // The counter never reaches DEBOUNCE_CYCLES: the accepting edge clears it instead.
  assign w_done   = w_differ && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt    <= '0;
        r_stable <= w_sync;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;
  // Look-ahead so a registered consumer lands in the same cycle as the stable rise.
  assign o_rise   = w_done & w_sync;

endmodule

`default_nettype wire

// File: rtl/motor_inputs.sv
// motor_inputs: debounces button and limit switches, emits a one-cycle activate pulse.
// Rev 1.0 -- optional stuck-limit fault check enabled by MOTOR_INPUTS_FAULT_EN.
`default_nettype none

module motor_inputs
  import motor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = MOTOR_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = MOTOR_SYNC_STAGES,
  parameter int CNT_W           = motor_cnt_w(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic up_limit_raw,
  input  logic dn_limit_raw,
  output logic activate,
  output logic up_limit,
  output logic dn_limit,
  output logic limit_fault
);

  logic [MOTOR_NUM_CH-1:0] w_raw;
  logic [MOTOR_NUM_CH-1:0] w_stable;
  logic [MOTOR_NUM_CH-1:0] w_rise;
  logic                    w_block;
  logic                    w_unused_rise;
  logic                    r_activate;

  always_comb begin
    w_raw         = '0;
    w_raw[CH_BTN] = btn_raw;
    w_raw[CH_UP]  = up_limit_raw;
    w_raw[CH_DN]  = dn_limit_raw;
  end

  for (genvar g = 0; g < MOTOR_NUM_CH; g++) begin : g_ch
    debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_raw    (w_raw[g]),
      .o_stable (w_stable[g]),
      .o_rise   (w_rise[g])
    );
  end

  // Limit channels only need their levels; their rise look-ahead is not consumed.
  assign w_unused_rise = &{1'b0, w_rise[CH_UP], w_rise[CH_DN]};

`ifdef MOTOR_INPUTS_FAULT_EN
  logic r_fault;
  logic w_fault_next;

  assign w_fault_next = r_fault | (w_stable[CH_UP] & w_stable[CH_DN]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_fault_next;
    end
  end

  // Blocking on the next fault value keeps activate low from the very edge the fault sets.
  assign w_block     = w_fault_next;
  assign limit_fault = r_fault;
`else
  assign w_block     = 1'b0;
  assign limit_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_activate <= 1'b0;
    end else begin
      r_activate <= w_rise[CH_BTN] & ~w_block;
    end
  end

  assign activate = r_activate;
  assign up_limit = w_stable[CH_UP];
  assign dn_limit = w_stable[CH_DN];

endmodule

`default_nettype wire
